// File: rtl/addsub_pkg.sv
// Shared types for the bit-serial add/subtract sequencer: FSM states and op encoding.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s_c,
   output logic co_c
);

   assign s_c  = a ^ b ^ ci;
   assign co_c = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/full_subtractor.sv
// Single-bit full-subtractor cell: d = a - b - bi, with borrow-out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d_c,
   output logic bo_c
);

   assign d_c  = a ^ b ^ bi;
   assign bo_c = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_bit_slice.sv
// One-bit add/subtract slice: adder and subtractor cells side by side, selected by op.
module serial_bit_slice
   import addsub_pkg::*;
(
   input  logic op,
   input  logic a,
   input  logic b,
   input  logic cbin,
   output logic res_c,
   output logic cbout_c
);

   logic sum_c, carry_c, diff_c, borrow_c;

   full_adder u_fa (
      .a    (a),
      .b    (b),
      .ci   (cbin),
      .s_c  (sum_c),
      .co_c (carry_c)
   );

   full_subtractor u_fs (
      .a    (a),
      .b    (b),
      .bi   (cbin),
      .d_c  (diff_c),
      .bo_c (borrow_c)
   );

   assign res_c   = (op == OP_SUB) ? diff_c   : sum_c;
   assign cbout_c = (op == OP_SUB) ? borrow_c : carry_c;

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer, LSB first, one bit per clock, start/busy/done handshake.
// SERIAL_ADDSUB_SEXT_IMM_EN adds imm_sel/imm16 to load B from a sign-extended 16-bit immediate.
module serial_addsub_seq
   import addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
`ifdef SERIAL_ADDSUB_SEXT_IMM_EN
   ,
   input  logic             imm_sel,
   input  logic [15:0]      imm16
`endif
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   state_t           state, state_nxt;
   logic             busy_nxt, done_nxt;
   logic [WIDTH-1:0] sh_a, sh_b, b_src_c;
   logic [CW-1:0]    cnt;
   logic             op_q, cy_q, a_msb, b_msb;
   logic             bit_res_c, bit_cy_c, ovf_c;
   logic             accept_c, last_c;

   assign accept_c = (state == IDLE) && start;
   assign last_c   = (cnt == CW'(WIDTH));

   // B operand source: port b, or the sign-extended immediate when selected
   always_comb begin
      b_src_c = b;
`ifdef SERIAL_ADDSUB_SEXT_IMM_EN
      if (imm_sel) begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            b_src_c[i] = (i < 16) ? imm16[4'(i)] : imm16[15];
         end
      end
`endif
   end

   serial_bit_slice u_slice (
      .op      (op_q),
      .a       (sh_a[0]),
      .b       (sh_b[0]),
      .cbin    (cy_q),
      .res_c   (bit_res_c),
      .cbout_c (bit_cy_c)
   );

   // Signed overflow from the operand sign bits captured at start
   always_comb begin
      if (op_q == OP_ADD) begin
         ovf_c = (a_msb == b_msb) && (result[WIDTH-1] != a_msb);
      end else begin
         ovf_c = (a_msb != b_msb) && (result[WIDTH-1] != a_msb);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // RUN spends WIDTH bit cycles plus one exit cycle, giving done one edge after the last bit
   always_comb begin
      state_nxt = state;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      unique case (state)
         IDLE:    if (start)  state_nxt = RUN;
         RUN:     if (last_c) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state_nxt == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= busy_nxt;
         done <= done_nxt;
      end
   end

   // Operand shifters, carry/borrow flop, bit counter and result assembly
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_a   <= '0;
         sh_b   <= '0;
         op_q   <= OP_ADD;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         cnt    <= '0;
         cy_q   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else if (accept_c) begin
         sh_a   <= a;
         sh_b   <= b_src_c;
         op_q   <= op;
         a_msb  <= a[WIDTH-1];
         b_msb  <= b_src_c[WIDTH-1];
         cnt    <= '0;
         cy_q   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else if (state == RUN) begin
         if (!last_c) begin
            sh_a   <= sh_a >> 1;
            sh_b   <= sh_b >> 1;
            result <= {bit_res_c, result[WIDTH-1:1]};
            cy_q   <= bit_cy_c;
            cnt    <= cnt + CW'(1);
         end else begin
            cout <= cy_q;
            ovf  <= ovf_c;
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Self-checking bench for serial_addsub_seq: directed table, handshake/reset sequences, random vs. arithmetic model.
module tb_serial_addsub_seq;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_n, start, op;
   logic [W-1:0] a, b;
   logic         busy, done, cout, ovf;
   logic [W-1:0] result;
   logic         imm_sel;
   logic [15:0]  imm16;

   int nchk = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   serial_addsub_seq #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .cout    (cout),
      .ovf     (ovf)
`ifdef SERIAL_ADDSUB_SEXT_IMM_EN
      ,
      .imm_sel (imm_sel),
      .imm16   (imm16)
`endif
   );

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain unsigned/signed arithmetic on the full operands
   task automatic model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic c, output logic v);
      longint sx, sy, full;
      logic [W:0] wide;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (o == 1'b0) begin
         wide = {1'b0, x} + {1'b0, y};
         r    = wide[W-1:0];
         c    = wide[W];
         full = sx + sy;
      end else begin
         r    = x - y;
         c    = (x < y);
         full = sx - sy;
      end
      v = (full != longint'($signed(r)));
   endtask

   // Issue one operation, scramble inputs after acceptance, wait (bounded) for done
   task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic isel, input logic [15:0] imm,
                         output logic [W-1:0] r, output logic c, output logic v, output int lat);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y; imm_sel = isel; imm16 = imm;
      @(posedge clk); #1;
      start = 1'b0; op = ~o; a = $urandom; b = $urandom; imm_sel = ~isel; imm16 = 16'($urandom);
      chk("busy_after_start", W'(busy), W'(1));
      lat = -1;
      for (int n = 1; n <= 3 * int'(W); n++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      r = result; c = cout; v = ovf;
      @(posedge clk); #1;
      chk("done_one_cycle", W'(done), W'(0));
      chk("busy_after_done", W'(busy), W'(0));
      chk("result_held", result, r);
   endtask

   initial begin
      logic [W-1:0] r, er, x, y;
      logic         c, v, ec, ev, o;
      int           lat, seen;

      tbl[0] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0};

      rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0; imm_sel = 1'b0; imm16 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));
      chk("rst_result", result, W'(0));
      chk("rst_cout", W'(cout), W'(0));
      chk("rst_ovf", W'(ovf), W'(0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 16'h0, r, c, v, lat);
         chk($sformatf("tbl%0d_latency", i), W'(lat), W'(W + 1));
         chk($sformatf("tbl%0d_result", i), r, tbl[i].res);
         chk($sformatf("tbl%0d_cout", i), W'(c), W'(tbl[i].cout));
         chk($sformatf("tbl%0d_ovf", i), W'(v), W'(tbl[i].ovf));
      end

      // Start during RUN is ignored; original operation completes on time
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'h0000_0005; b = 32'h0000_0003;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      start = 1'b1; op = 1'b1; a = 32'h1234_5678; b = 32'h0000_1111;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int n = 7; n <= 3 * int'(W); n++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      chk("ignore_latency", W'(lat), W'(W + 1));
      chk("ignore_result", result, 32'h0000_0008);
      @(posedge clk); #1;
      chk("ignore_idle", W'(busy), W'(0));

      // Reset mid-RUN aborts with no done pulse
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'h0000_00F0; b = 32'h0000_000F;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy", W'(busy), W'(0));
      chk("abort_result", result, W'(0));
      chk("abort_done", W'(done), W'(0));
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      chk("abort_no_done", W'(seen), W'(0));

      // Random operations against the arithmetic model
      for (int i = 0; i < 30; i++) begin
         o = 1'($urandom_range(0, 1));
         x = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + W'($urandom_range(0, 2)) : W'($urandom);
         y = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
         model(o, x, y, er, ec, ev);
         run_op(o, x, y, 1'b0, 16'h0, r, c, v, lat);
         chk($sformatf("rnd%0d_latency", i), W'(lat), W'(W + 1));
         chk($sformatf("rnd%0d_result op=%0d a=%h b=%h", i, o, x, y), r, er);
         chk($sformatf("rnd%0d_cout", i), W'(c), W'(ec));
         chk($sformatf("rnd%0d_ovf", i), W'(v), W'(ev));
      end

`ifdef SERIAL_ADDSUB_SEXT_IMM_EN
      run_op(1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 16'h8000, r, c, v, lat);
      chk("imm_neg_result", r, 32'hFFFF_8000);
      run_op(1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 16'h7FFF, r, c, v, lat);
      chk("imm_pos_result", r, 32'h0000_7FFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
